usrt_tx_framer: RTL and testbench

Transmit-side buffer and framer for the USRT link. It accepts bytes from the APB write path into a small FIFO. It wraps each byte into the 11-bit USRT frame and shifts the frame out onto the serial line, one bit per baud tick. It sits between the APB write decode and the physical line, in place of the separate write-register/serializer pair. All logic runs in the pClk domain; the baud generator's one-cycle tick acts as a clock enable.

---
 rtl/usrt_tx_framer_if.sv | 9 +
 rtl/usrt_tx_framer.sv | 108 ++++++++++
 tb/tb_usrt_tx_framer.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/usrt_tx_framer_if.sv
// Byte write handshake between the APB write decode and the USRT transmit framer.
interface usrt_tx_framer_if;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       wr_ready;

  modport master (output wr_valid, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_data, output wr_ready);
endinterface

// File: rtl/usrt_tx_framer.sv
// USRT transmit FIFO plus 11-bit framer/serializer advanced by baud_tick.
// Optional feature macro: USRT_TX_PARITY_EN (bit9 = XOR parity; otherwise bit9 = 0).
module usrt_tx_framer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   pClk,
  input  logic                   pReset,
  usrt_tx_framer_if.slave        wr,
  input  logic                   baud_tick,
  output logic                   Rx,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t      state, state_n;
  logic [AW:0] wptr, rptr, wptr_n, rptr_n;
  logic [7:0]  mem [DEPTH];
  logic [10:0] shreg, shreg_n;
  logic [3:0]  bitcnt, bitcnt_n;
  logic        full, empty, push, pop, parity;
  logic [7:0]  head;
  logic [10:0] frame;

  assign empty       = (wptr == rptr);
  assign full        = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign wr.wr_ready = !full;
  assign push        = wr.wr_valid && !full;
  assign head        = mem[rptr[AW-1:0]];
  assign level       = wptr - rptr;

`ifdef USRT_TX_PARITY_EN
  assign parity = ^head;
`else
  assign parity = 1'b0;
`endif

  // Stop bit at the top so shifting right leaves the start bit on Rx first.
  assign frame = {1'b0, parity, head, 1'b1};

  always_comb begin
    state_n  = state;
    shreg_n  = shreg;
    bitcnt_n = bitcnt;
    pop      = 1'b0;
    case (state)
      IDLE: begin
        if (baud_tick && !empty) begin
          pop      = 1'b1;
          shreg_n  = frame;
          bitcnt_n = '0;
          state_n  = SHIFT;
        end
      end
      SHIFT: begin
        if (baud_tick) begin
          if (bitcnt == 4'd10) begin
            if (!empty) begin
              pop      = 1'b1;
              shreg_n  = frame;
              bitcnt_n = '0;
            end else begin
              shreg_n  = '0;
              bitcnt_n = '0;
              state_n  = IDLE;
            end
          end else begin
            shreg_n  = {1'b0, shreg[10:1]};
            bitcnt_n = bitcnt + 4'd1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign wptr_n = wptr + {{AW{1'b0}}, push};
  assign rptr_n = rptr + {{AW{1'b0}}, pop};

  // Rx and busy are registered from next-state values so they carry no input-to-output path.
  always_ff @(posedge pClk or negedge pReset) begin
    if (!pReset) begin
      state  <= IDLE;
      shreg  <= '0;
      bitcnt <= '0;
      wptr   <= '0;
      rptr   <= '0;
      Rx     <= 1'b0;
      busy   <= 1'b0;
    end else begin
      state  <= state_n;
      shreg  <= shreg_n;
      bitcnt <= bitcnt_n;
      wptr   <= wptr_n;
      rptr   <= rptr_n;
      Rx     <= (state_n == SHIFT) ? shreg_n[0] : 1'b0;
      busy   <= (state_n == SHIFT) || (wptr_n != rptr_n);
    end
  end

  always_ff @(posedge pClk) begin
    if (push) mem[wptr[AW-1:0]] <= wr.wr_data;
  end

endmodule

// File: tb/tb_usrt_tx_framer.sv
// Randomized bench for usrt_tx_framer against a queue-based frame model, plus directed literal checks.
module tb_usrt_tx_framer;
  localparam int unsigned DEPTH = 4;

  logic       pClk = 1'b0;
  logic       pReset = 1'b0;
  logic       baud_tick = 1'b0;
  logic       Rx, busy;
  logic [2:0] level;

  usrt_tx_framer_if wr();

  usrt_tx_framer #(.DEPTH(DEPTH)) dut (
    .pClk(pClk), .pReset(pReset), .wr(wr), .baud_tick(baud_tick),
    .Rx(Rx), .busy(busy), .level(level)
  );

  always #5 pClk = ~pClk;

  int total = 0;
  int bad = 0;

  logic [7:0] q[$];
  int         idx = -1;
  logic [7:0] cur = '0;
  logic       m_push;
  logic [7:0] m_data;

  function automatic logic frame_bit(input logic [7:0] d, input int i);
    logic r;
    r = 1'b0;
    if (i == 0) r = 1'b1;
    else if (i >= 1 && i <= 8) r = d[i-1];
`ifdef USRT_TX_PARITY_EN
    else if (i == 9) r = ^d;
`endif
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: bytes wait in q; idx is the index of the frame bit on the line, -1 when idle.
  always @(posedge pClk or negedge pReset) begin
    if (!pReset) begin
      q.delete();
      idx = -1;
    end else begin
      m_push = wr.wr_valid && (q.size() < DEPTH);
      m_data = wr.wr_data;
      if (baud_tick) begin
        if (idx < 0 || idx == 10) begin
          if (q.size() > 0) begin
            cur = q.pop_front();
            idx = 0;
          end else begin
            idx = -1;
          end
        end else begin
          idx++;
        end
      end
      if (m_push) q.push_back(m_data);
    end
  end

  always @(negedge pClk) begin
    check("rx", {31'd0, Rx}, {31'd0, (idx >= 0) ? frame_bit(cur, idx) : 1'b0});
    check("busy", {31'd0, busy}, {31'd0, (idx >= 0) || (q.size() > 0)});
    check("level", {29'd0, level}, q.size());
    check("wr_ready", {31'd0, wr.wr_ready}, {31'd0, q.size() < DEPTH});
  end

  task automatic cyc();
    @(posedge pClk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    wr.wr_valid = 1'b1;
    wr.wr_data  = d;
    cyc();
    wr.wr_valid = 1'b0;
  endtask

  task automatic tick(input int gap);
    repeat (gap) cyc();
    baud_tick = 1'b1;
    cyc();
    baud_tick = 1'b0;
  endtask

  logic [10:0] exp_a5;
  logic [21:0] exp_b2b;
  logic        exp_par;

  initial begin
    wr.wr_valid = 1'b1;
    wr.wr_data  = 8'h55;
    repeat (3) cyc();
    check("rst_rx", {31'd0, Rx}, 32'd0);
    check("rst_level", {29'd0, level}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_wr_ready", {31'd0, wr.wr_ready}, 32'd1);
    wr.wr_valid = 1'b0;
    pReset = 1'b1;
    cyc();

    // 0xA5 with ticks 80 cycles apart: bits 1,1,0,1,0,0,1,0,1,0,0
    exp_a5 = 11'b00101001011;
    push(8'hA5);
    check("push_level", {29'd0, level}, 32'd1);
    check("push_busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 11; i++) begin
      tick(79);
      check("a5_bit", {31'd0, Rx}, {31'd0, exp_a5[i]});
    end
    tick(79);
    check("a5_end_rx", {31'd0, Rx}, 32'd0);
    check("a5_end_busy", {31'd0, busy}, 32'd0);

`ifdef USRT_TX_PARITY_EN
    exp_par = 1'b1;
`else
    exp_par = 1'b0;
`endif
    push(8'h01);
    repeat (10) tick(3);
    check("par01_bit9", {31'd0, Rx}, {31'd0, exp_par});
    repeat (2) tick(3);

    for (int i = 0; i < 5; i++) begin
      push(8'h10 + 8'(i));
      if (i == 3) check("full_wr_ready", {31'd0, wr.wr_ready}, 32'd0);
    end
    check("full_level", {29'd0, level}, 32'd4);
    tick(0);
    check("pop_level", {29'd0, level}, 32'd3);
    check("pop_wr_ready", {31'd0, wr.wr_ready}, 32'd1);
    check("pop_rx_start", {31'd0, Rx}, 32'd1);
    repeat (46) tick(1);

    exp_b2b = {11'b00110000111, 11'b00001111001};
    push(8'h3C);
    push(8'hC3);
    for (int i = 0; i < 22; i++) begin
      tick(2);
      check("b2b_bit", {31'd0, Rx}, {31'd0, exp_b2b[i]});
    end
    tick(2);
    check("b2b_end_busy", {31'd0, busy}, 32'd0);

    push(8'hFF);
    push(8'h81);
    push(8'h42);
    repeat (5) tick(2);
    check("mid_rx", {31'd0, Rx}, 32'd1);
    check("mid_level", {29'd0, level}, 32'd2);
    @(posedge pClk);
    #2;
    pReset = 1'b0;
    #1;
    check("async_rst_rx", {31'd0, Rx}, 32'd0);
    check("async_rst_level", {29'd0, level}, 32'd0);
    cyc();
    pReset = 1'b1;
    repeat (15) tick(1);
    check("post_rst_busy", {31'd0, busy}, 32'd0);

    for (int i = 0; i < 3000; i++) begin
      wr.wr_valid = 1'($urandom_range(0, 1));
      wr.wr_data  = 8'($urandom);
      baud_tick   = ($urandom_range(0, 3) == 0);
      cyc();
    end
    wr.wr_valid = 1'b0;
    baud_tick   = 1'b0;
    repeat (60) tick(0);
    check("drain_busy", {31'd0, busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
